// File: rtl/padding_stream_if.sv
// Element stream bundle for the zero-padding stage: unpadded input side plus padded output side.
interface padding_stream_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  data_in_valid;
  logic                  data_in_ready;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_out_valid;
  logic                  data_out_ready;
  logic                  data_out_last;

  // master: the environment feeding the stage and draining its output
  modport master (
    output data_in, data_in_valid, data_out_ready,
    input  data_in_ready, data_out, data_out_valid, data_out_last
  );

  // slave: the padding stage itself
  modport slave (
    input  data_in, data_in_valid, data_out_ready,
    output data_in_ready, data_out, data_out_valid, data_out_last
  );
endinterface

// File: rtl/padding_stream.sv
// Streaming zero-padding stage: wraps each IMG_HEIGHT x IMG_WIDTH x CHANNELS frame in a PAD_VALUE border.
// Zero latency; only the output-position counters are stored.
module padding_stream #(
  parameter int unsigned           DATA_WIDTH     = 32,
  parameter int unsigned           IMG_WIDTH      = 4,
  parameter int unsigned           IMG_HEIGHT     = 3,
  parameter int unsigned           PADDING_WIDTH  = 1,
  parameter int unsigned           PADDING_HEIGHT = 1,
  parameter int unsigned           CHANNELS       = 2,
  parameter logic [DATA_WIDTH-1:0] PAD_VALUE      = '0
) (
  input logic             clk,
  input logic             rst,
  padding_stream_if.slave stream
);

  localparam int unsigned PW_TOT = IMG_WIDTH + 2 * PADDING_WIDTH;
  localparam int unsigned PH_TOT = IMG_HEIGHT + 2 * PADDING_HEIGHT;
  localparam int unsigned CW     = $clog2(CHANNELS) + 1;
  localparam int unsigned XW     = $clog2(PW_TOT) + 1;
  localparam int unsigned YW     = $clog2(PH_TOT) + 1;

  logic [CW-1:0]         c;
  logic [XW-1:0]         x;
  logic [YW-1:0]         y;
  logic                  c_end;
  logic                  x_end;
  logic                  y_end;
  logic                  in_pad;
  logic                  fire;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_last;
  logic                  in_ready;

  // Position decode and output mux. The border test subtracts the pad offset and relies on
  // unsigned wrap, so positions left/above the image land far above the image extent.
  always_comb begin
    c_end  = (c == CW'(CHANNELS - 1));
    x_end  = (x == XW'(PW_TOT - 1));
    y_end  = (y == YW'(PH_TOT - 1));
    in_pad = (XW'(x - XW'(PADDING_WIDTH)) >= XW'(IMG_WIDTH)) ||
             (YW'(y - YW'(PADDING_HEIGHT)) >= YW'(IMG_HEIGHT));

    out_data  = PAD_VALUE;
    out_valid = 1'b0;
    in_ready  = 1'b0;
    out_last  = 1'b0;
    if (!rst) begin
      if (in_pad) begin
        out_valid = 1'b1;
      end else begin
        out_data  = stream.data_in;
        out_valid = stream.data_in_valid;
        in_ready  = stream.data_out_ready;
      end
      out_last = out_valid && c_end && x_end && y_end;
    end
    fire = out_valid && stream.data_out_ready;
  end

  // Counters hold the next output position; channel fastest, then x, then y.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c <= '0;
      x <= '0;
      y <= '0;
    end else if (fire) begin
      if (c_end) begin
        c <= '0;
        if (x_end) begin
          x <= '0;
          y <= y_end ? '0 : y + YW'(1);
        end else begin
          x <= x + XW'(1);
        end
      end else begin
        c <= c + CW'(1);
      end
    end
  end

  assign stream.data_out       = out_data;
  assign stream.data_out_valid = out_valid;
  assign stream.data_out_last  = out_last;
  assign stream.data_in_ready  = in_ready;

endmodule

// File: tb/tb_padding_stream.sv
// Randomized bench for padding_stream: five geometries checked against a frame-level reference
// built directly from the padding rules, including back-to-back frames, stalls and mid-frame reset.
module tb_padding_stream;

  localparam int N = 5;
  localparam int unsigned CFG_W  [N] = '{4, 2, 1, 4, 3};
  localparam int unsigned CFG_H  [N] = '{3, 2, 1, 3, 2};
  localparam int unsigned CFG_PW [N] = '{1, 1, 1, 0, 2};
  localparam int unsigned CFG_PH [N] = '{1, 1, 1, 0, 0};
  localparam int unsigned CFG_C  [N] = '{2, 1, 2, 2, 3};
  localparam logic [31:0] CFG_PAD[N] = '{32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0, 32'h0000_00FF};

  logic          clk = 1'b0;
  logic [N-1:0]  rst;
  logic [31:0]   din  [N];
  logic [N-1:0]  din_valid;
  logic [N-1:0]  din_ready;
  logic [31:0]   dout [N];
  logic [N-1:0]  dout_valid;
  logic [N-1:0]  dout_ready;
  logic [N-1:0]  dout_last;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  padding_stream_if #(.DATA_WIDTH(32)) bus0 ();
  padding_stream_if #(.DATA_WIDTH(32)) bus1 ();
  padding_stream_if #(.DATA_WIDTH(32)) bus2 ();
  padding_stream_if #(.DATA_WIDTH(32)) bus3 ();
  padding_stream_if #(.DATA_WIDTH(32)) bus4 ();

  padding_stream #(.DATA_WIDTH(32), .IMG_WIDTH(4), .IMG_HEIGHT(3), .PADDING_WIDTH(1),
                   .PADDING_HEIGHT(1), .CHANNELS(2), .PAD_VALUE(32'hDEAD_BEEF))
    dut0 (.clk(clk), .rst(rst[0]), .stream(bus0.slave));
  padding_stream #(.DATA_WIDTH(32), .IMG_WIDTH(2), .IMG_HEIGHT(2), .PADDING_WIDTH(1),
                   .PADDING_HEIGHT(1), .CHANNELS(1), .PAD_VALUE(32'h0))
    dut1 (.clk(clk), .rst(rst[1]), .stream(bus1.slave));
  padding_stream #(.DATA_WIDTH(32), .IMG_WIDTH(1), .IMG_HEIGHT(1), .PADDING_WIDTH(1),
                   .PADDING_HEIGHT(1), .CHANNELS(2), .PAD_VALUE(32'h0))
    dut2 (.clk(clk), .rst(rst[2]), .stream(bus2.slave));
  padding_stream #(.DATA_WIDTH(32), .IMG_WIDTH(4), .IMG_HEIGHT(3), .PADDING_WIDTH(0),
                   .PADDING_HEIGHT(0), .CHANNELS(2), .PAD_VALUE(32'h0))
    dut3 (.clk(clk), .rst(rst[3]), .stream(bus3.slave));
  padding_stream #(.DATA_WIDTH(32), .IMG_WIDTH(3), .IMG_HEIGHT(2), .PADDING_WIDTH(2),
                   .PADDING_HEIGHT(0), .CHANNELS(3), .PAD_VALUE(32'h0000_00FF))
    dut4 (.clk(clk), .rst(rst[4]), .stream(bus4.slave));

  assign bus0.data_in = din[0];  assign bus0.data_in_valid = din_valid[0];  assign bus0.data_out_ready = dout_ready[0];
  assign bus1.data_in = din[1];  assign bus1.data_in_valid = din_valid[1];  assign bus1.data_out_ready = dout_ready[1];
  assign bus2.data_in = din[2];  assign bus2.data_in_valid = din_valid[2];  assign bus2.data_out_ready = dout_ready[2];
  assign bus3.data_in = din[3];  assign bus3.data_in_valid = din_valid[3];  assign bus3.data_out_ready = dout_ready[3];
  assign bus4.data_in = din[4];  assign bus4.data_in_valid = din_valid[4];  assign bus4.data_out_ready = dout_ready[4];

  assign dout[0] = bus0.data_out;  assign dout_valid[0] = bus0.data_out_valid;
  assign dout[1] = bus1.data_out;  assign dout_valid[1] = bus1.data_out_valid;
  assign dout[2] = bus2.data_out;  assign dout_valid[2] = bus2.data_out_valid;
  assign dout[3] = bus3.data_out;  assign dout_valid[3] = bus3.data_out_valid;
  assign dout[4] = bus4.data_out;  assign dout_valid[4] = bus4.data_out_valid;
  assign dout_last[0] = bus0.data_out_last;  assign din_ready[0] = bus0.data_in_ready;
  assign dout_last[1] = bus1.data_out_last;  assign din_ready[1] = bus1.data_in_ready;
  assign dout_last[2] = bus2.data_out_last;  assign din_ready[2] = bus2.data_in_ready;
  assign dout_last[3] = bus3.data_out_last;  assign din_ready[3] = bus3.data_in_ready;
  assign dout_last[4] = bus4.data_out_last;  assign din_ready[4] = bus4.data_in_ready;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Checks the idle/reset output state of one instance while rst is high.
  task automatic check_reset_outputs(input int i);
    check_eq($sformatf("dut%0d_rst_out_valid", i), 64'(dout_valid[i]), 64'd0);
    check_eq($sformatf("dut%0d_rst_in_ready", i), 64'(din_ready[i]), 64'd0);
    check_eq($sformatf("dut%0d_rst_last", i), 64'(dout_last[i]), 64'd0);
    check_eq($sformatf("dut%0d_rst_data", i), 64'(dout[i]), 64'(CFG_PAD[i]));
  endtask

  // Streams `frames` frames through instance i with random valid/ready duty cycles (percent)
  // and compares every cycle against the expected padded frame sequence.
  task automatic run_stream(input int i, input int frames, input int pin, input int pout, input bit tight);
    int unsigned pwt = CFG_W[i] + 2 * CFG_PW[i];
    int unsigned pht = CFG_H[i] + 2 * CFG_PH[i];
    int unsigned fl  = pwt * pht * CFG_C[i];
    logic [31:0] src[$];
    logic [31:0] exp[$];
    bit          pad[$];
    int          src_total;
    int          budget;
    int          k = 0;
    int          cycles = 0;
    int          n_in = 0;
    bit          hs_in = 1'b0;
    bit          border;
    logic [31:0] v;

    for (int f = 0; f < frames; f++)
      for (int unsigned y = 0; y < pht; y++)
        for (int unsigned x = 0; x < pwt; x++)
          for (int unsigned c = 0; c < CFG_C[i]; c++) begin
            border = (x < CFG_PW[i]) || (x >= CFG_PW[i] + CFG_W[i]) ||
                     (y < CFG_PH[i]) || (y >= CFG_PH[i] + CFG_H[i]);
            if (border) begin
              exp.push_back(CFG_PAD[i]);
            end else begin
              v = $urandom;
              src.push_back(v);
              exp.push_back(v);
            end
            pad.push_back(border);
          end
    src_total = src.size();
    budget    = 20 * exp.size() + 50;

    while (k < exp.size() && cycles < budget) begin
      @(posedge clk);
      #1;
      if (hs_in) void'(src.pop_front());
      if (!(din_valid[i] && !hs_in))
        din_valid[i] = (src.size() > 0) && ($urandom_range(99) < pin);
      din[i] = (src.size() > 0) ? src[0] : 32'h0;
      dout_ready[i] = ($urandom_range(99) < pout);
      @(negedge clk);
      cycles++;
      if (pad[k]) begin
        check_eq($sformatf("dut%0d_border_valid", i), 64'(dout_valid[i]), 64'd1);
        check_eq($sformatf("dut%0d_border_in_ready", i), 64'(din_ready[i]), 64'd0);
      end else begin
        check_eq($sformatf("dut%0d_image_valid", i), 64'(dout_valid[i]), 64'(din_valid[i]));
        check_eq($sformatf("dut%0d_image_in_ready", i), 64'(din_ready[i]), 64'(dout_ready[i]));
      end
      if (dout_valid[i])
        check_eq($sformatf("dut%0d_data_k%0d", i, k), 64'(dout[i]), 64'(exp[k]));
      check_eq($sformatf("dut%0d_last_k%0d", i, k), 64'(dout_last[i]),
               64'(dout_valid[i] && ((k % fl) == fl - 1)));
      hs_in = din_valid[i] && din_ready[i];
      if (hs_in) n_in++;
      if (dout_valid[i] && dout_ready[i]) k++;
    end

    @(posedge clk);
    #1;
    din_valid[i]  = 1'b0;
    dout_ready[i] = 1'b0;
    check_eq($sformatf("dut%0d_out_count", i), 64'(k), 64'(exp.size()));
    check_eq($sformatf("dut%0d_in_count", i), 64'(n_in), 64'(src_total));
    if (tight) check_eq($sformatf("dut%0d_no_gap_cycles", i), 64'(cycles), 64'(exp.size()));
  endtask

  initial begin
    int outs;
    int guard;

    rst        = '1;
    din_valid  = '1;
    dout_ready = '1;
    for (int i = 0; i < N; i++) din[i] = 32'h1234_5678;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < N; i++) check_reset_outputs(i);
    @(posedge clk);
    #1;
    din_valid  = '0;
    dout_ready = '0;
    rst        = '0;

    for (int i = 0; i < N; i++) begin
      run_stream(i, 2, 100, 100, 1'b1);
      run_stream(i, 2, 60, 50, 1'b0);
      run_stream(i, 1, 30, 90, 1'b0);
    end

    // Mid-frame reset on instance 0 after six output handshakes.
    outs  = 0;
    guard = 0;
    din_valid[0]  = 1'b1;
    dout_ready[0] = 1'b1;
    din[0]        = 32'hCAFE_0001;
    while (outs < 6 && guard < 100) begin
      @(negedge clk);
      guard++;
      if (dout_valid[0] && dout_ready[0]) outs++;
    end
    check_eq("dut0_pre_reset_handshakes", 64'(outs), 64'd6);
    @(posedge clk);
    #1;
    rst[0] = 1'b1;
    #1;
    check_reset_outputs(0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs(0);
    @(posedge clk);
    #1;
    rst[0]        = 1'b0;
    din_valid[0]  = 1'b0;
    dout_ready[0] = 1'b0;
    run_stream(0, 1, 100, 100, 1'b1);
    run_stream(0, 1, 70, 70, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
